// File: rtl/crc_arb_pkg.sv
// Shared definitions for crc_engine_arbiter: FSM encoding and default sizing.
package crc_arb_pkg;

  localparam int NUM_REQ_DEF     = 4;
  localparam int ID_W_DEF        = 2;
  localparam int CRC_W_DEF       = 32;
  localparam int TIMEOUT_CYC_DEF = 1024;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    STREAM   = 3'd2,
    WAIT_CRC = 3'd3,
    RESP     = 3'd4
  } arb_state_e;

endpackage

// File: rtl/crc_engine_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i, cyclically.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [ID_W-1:0]    gnt_idx_o,
  output logic               gnt_any_o
);

  logic [ID_W-1:0] hi_idx, lo_idx;
  logic            hi_any, lo_any;

  // Descending scans so the lowest qualifying index is the one left standing.
  always_comb begin
    hi_idx = '0;
    hi_any = 1'b0;
    lo_idx = '0;
    lo_any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        lo_idx = ID_W'(i);
        lo_any = 1'b1;
        if (i >= int'(ptr_i)) begin
          hi_idx = ID_W'(i);
          hi_any = 1'b1;
        end
      end
    end
  end

  assign gnt_idx_o = hi_any ? hi_idx : lo_idx;
  assign gnt_any_o = lo_any;

endmodule

// File: rtl/crc_engine_arbiter.sv
// Round-robin sharing of one byte-serial CRC engine among NUM_REQ frame sources.
// Optional engine watchdog enabled by defining CRC_ARB_TIMEOUT_EN.
module crc_engine_arbiter
  import crc_arb_pkg::*;
#(
  parameter int NUM_REQ     = NUM_REQ_DEF,
  parameter int ID_W        = ID_W_DEF,
  parameter int CRC_W       = CRC_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [ID_W-1:0]      resp_id,
  output logic [CRC_W-1:0]     resp_crc,
  output logic                 resp_err,
  output logic                 busy,
  output logic                 crc_start,
  output logic                 crc_data_valid,
  output logic [7:0]           crc_data,
  input  logic                 crc_ready,
  input  logic [CRC_W-1:0]     crc_out
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || ID_W != $clog2(NUM_REQ) || TIMEOUT_CYC < 1) begin : g_param_err
    $error("crc_engine_arbiter: unsupported parameter set");
  end

  arb_state_e      state_q;
  logic [ID_W-1:0] gnt_id_q, rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] resp_id_q;
  logic [CRC_W-1:0] resp_crc_q;
  logic [ID_W-1:0] arb_idx;
  logic            arb_any;
  logic            gnt_valid, gnt_last;
  logic [7:0]      gnt_byte;
  logic            streaming;

`ifdef CRC_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] to_cnt_q;
  logic             resp_err_q;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req_i     (req_valid),
    .ptr_i     (rr_ptr_q),
    .gnt_idx_o (arb_idx),
    .gnt_any_o (arb_any)
  );

  assign streaming = (state_q == STREAM);

  // Granted port's byte lane, selected by compare rather than variable slicing.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_last  = 1'b0;
    gnt_byte  = '0;
    req_ready = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_id_q == ID_W'(k)) begin
        gnt_valid    = req_valid[k];
        gnt_last     = req_last[k];
        gnt_byte     = req_data[k*8 +: 8];
        req_ready[k] = streaming;
      end
    end
  end

  assign rr_ptr_d = (gnt_id_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_q + 1'b1;

  assign busy           = (state_q != IDLE);
  assign crc_start      = (state_q == START);
  assign crc_data_valid = streaming & gnt_valid;
  assign crc_data       = streaming ? gnt_byte : 8'h00;
  assign resp_valid     = (state_q == RESP);
  assign resp_id        = resp_id_q;
  assign resp_crc       = resp_crc_q;
`ifdef CRC_ARB_TIMEOUT_EN
  assign resp_err       = resp_err_q;
`else
  assign resp_err       = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_id_q   <= '0;
      rr_ptr_q   <= '0;
      resp_id_q  <= '0;
      resp_crc_q <= '0;
`ifdef CRC_ARB_TIMEOUT_EN
      to_cnt_q   <= '0;
      resp_err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          // Grant from valid alone; the first byte is taken only in STREAM.
          if (arb_any) begin
            gnt_id_q <= arb_idx;
            state_q  <= START;
          end
        end
        START: state_q <= STREAM;
        STREAM: begin
          if (gnt_valid && gnt_last) begin
            state_q <= WAIT_CRC;
`ifdef CRC_ARB_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
          end
        end
        WAIT_CRC: begin
          if (crc_ready) begin
            resp_crc_q <= crc_out;
            resp_id_q  <= gnt_id_q;
            state_q    <= RESP;
`ifdef CRC_ARB_TIMEOUT_EN
            resp_err_q <= 1'b0;
          end else if (to_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            resp_crc_q <= '0;
            resp_id_q  <= gnt_id_q;
            resp_err_q <= 1'b1;
            state_q    <= RESP;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
`endif
          end
        end
        RESP: begin
          if (resp_ready) begin
            rr_ptr_q <= rr_ptr_d;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_engine_arbiter.sv
// Directed + randomized bench: tb-side CRC-32 engine model and round-robin scoreboard.
module tb_crc_engine_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int CW  = 32;
`ifdef CRC_ARB_TIMEOUT_EN
  localparam int TO  = 16;
`else
  localparam int TO  = 1024;
`endif

  logic            clk, rst;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [N*8-1:0]  req_data;
  logic            resp_valid, resp_ready, resp_err, busy;
  logic [IDW-1:0]  resp_id;
  logic [CW-1:0]   resp_crc, crc_out;
  logic            crc_start, crc_data_valid, crc_ready;
  logic [7:0]      crc_data;

  crc_engine_arbiter #(.NUM_REQ(N), .ID_W(IDW), .CRC_W(CW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_crc(resp_crc),
    .resp_err(resp_err), .busy(busy),
    .crc_start(crc_start), .crc_data_valid(crc_data_valid), .crc_data(crc_data),
    .crc_ready(crc_ready), .crc_out(crc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Scoreboard state: open frames, finished frames awaiting a response, model pointer.
  logic [7:0]  q_frm[N][$];
  logic [31:0] exp_crc_q[N][$];
  int          pos[N], gap_left[N];
  int          mptr = 0;
  int          exp_frames, exp_bytes, n_start, n_strobe;
  int          cyc = 0, last_done_cyc = 0;
  int          force_gap_k = -1, late_trig_k = -1, late_k = -1, stall_left = 0;
  bit          rnd_gap = 0, rnd_rdy = 0, expect_to = 0, eng_hold = 0;
  bit          hold_v = 0, prev_rv = 0;
  logic [IDW-1:0] prev_id;
  logic [CW-1:0]  prev_crc, last_resp_crc;
  int          id_log[$];
  logic [31:0] eng = 32'hFFFFFFFF;
  bit          eng_started = 0, s_start = 0, s_dv = 0;
  logic [7:0]  s_d = 8'h0;

  task automatic add_frame(input int k, input int kind, input int len);
    logic [7:0] b;
    if (kind == 1) begin
      for (int i = 0; i < 9; i++) begin b = 8'h31 + 8'(i); q_frm[k].push_back(b); end
    end else if (kind == 2) begin
      b = 8'h00; q_frm[k].push_back(b);
    end else begin
      for (int i = 0; i < len; i++) begin b = 8'($urandom); q_frm[k].push_back(b); end
    end
    pos[k] = 0; gap_left[k] = 0;
    exp_frames++; exp_bytes += q_frm[k].size();
  endtask

  task automatic check_resp();
    bit cand[N];
    int e;
    logic [31:0] c;
    for (int k = 0; k < N; k++) cand[k] = (q_frm[k].size() > 0) || (exp_crc_q[k].size() > 0);
    e = -1;
    for (int i = 0; i < N; i++) if (e < 0 && cand[(mptr + i) % N]) e = (mptr + i) % N;
    chk("resp_id", {32'h0, 30'h0, resp_id}, 64'(e));
    if (e >= 0 && exp_crc_q[e].size() > 0) begin
      c = exp_crc_q[e].pop_front();
      chk("resp_crc", resp_crc, expect_to ? 64'h0 : 64'(c));
    end else chk("resp_owner_has_frame", 64'h0, 64'h1);
    chk("resp_err", resp_err, 64'(expect_to));
    last_resp_crc = resp_crc;
    id_log.push_back(int'(resp_id));
    mptr = (int'(resp_id) + 1) % N;
  endtask

  task automatic step();
    logic [N-1:0] hs;
    logic [31:0] done_crc;
    for (int k = 0; k < N; k++) begin
      if (q_frm[k].size() > 0 && gap_left[k] == 0) begin
        req_valid[k] = 1'b1;
        req_data[k*8 +: 8] = q_frm[k][pos[k]];
        req_last[k] = (pos[k] == q_frm[k].size() - 1);
      end else begin
        req_valid[k] = 1'b0; req_data[k*8 +: 8] = 8'h0; req_last[k] = 1'b0;
      end
    end
    resp_ready = (stall_left > 0) ? 1'b0 : (rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
    #4;
    hs = req_valid & req_ready;
    if (!$onehot0(req_ready)) chk("ready_onehot0", {32'h0, 28'h0, req_ready}, 64'h1);
    if (crc_data_valid !== (|hs)) chk("strobe_vs_handshake", crc_data_valid, 64'(|hs));
    for (int k = 0; k < N; k++)
      if (hs[k] && crc_data !== q_frm[k][pos[k]]) chk("strobe_byte", crc_data, 64'(q_frm[k][pos[k]]));
    if (crc_data_valid) n_strobe++;
    if (crc_start) n_start++;
    if (hold_v) begin
      chk("stall_valid", resp_valid, 64'h1);
      chk("stall_id", resp_id, 64'(prev_id));
      chk("stall_crc", resp_crc, 64'(prev_crc));
    end
    if (resp_valid && !prev_rv && expect_to) chk("timeout_latency", 64'(cyc - last_done_cyc), 64'd17);
    if (resp_valid && resp_ready) check_resp();
    hold_v = resp_valid && !resp_ready;
    prev_id = resp_id; prev_crc = resp_crc; prev_rv = resp_valid;
    if (resp_valid && stall_left > 0) stall_left--;
    s_start = crc_start; s_dv = crc_data_valid; s_d = crc_data;
    @(posedge clk); #1;
    if (s_start) begin eng = 32'hFFFFFFFF; eng_started = 1; end
    else if (s_dv) eng = crc_upd(eng, s_d);
    crc_ready = eng_started && !s_start && !s_dv && !eng_hold;
    crc_out = ~eng;
    for (int k = 0; k < N; k++) begin
      if (hs[k]) begin
        if (k == late_trig_k && pos[k] == 0 && late_k >= 0) begin
          add_frame(late_k, 1, 9); late_k = -1;
        end
        pos[k]++;
        if (pos[k] == q_frm[k].size()) begin
          done_crc = 32'hFFFFFFFF;
          foreach (q_frm[k][i]) done_crc = crc_upd(done_crc, q_frm[k][i]);
          exp_crc_q[k].push_back(~done_crc);
          q_frm[k].delete(); pos[k] = 0;
          last_done_cyc = cyc;
        end else if (k == force_gap_k && pos[k] == 4) begin
          gap_left[k] = 3; force_gap_k = -1;
        end else if (rnd_gap && $urandom_range(0, 3) == 0) gap_left[k] = $urandom_range(1, 3);
      end else if (gap_left[k] > 0) gap_left[k]--;
    end
    cyc++;
  endtask

  function automatic bit all_done();
    for (int k = 0; k < N; k++) if (q_frm[k].size() > 0 || exp_crc_q[k].size() > 0) return 0;
    return 1;
  endfunction

  task automatic run_round(input string tag, input int budget);
    int t;
    t = 0;
    while (!all_done() && t < budget) begin step(); t++; end
    if (t >= budget) chk({tag, "_cycle_budget"}, 64'h0, 64'h1);
    step(); step();
    chk({tag, "_busy_idle"}, busy, 64'h0);
    chk({tag, "_start_pulses"}, 64'(n_start), 64'(exp_frames));
    chk({tag, "_strobes"}, 64'(n_strobe), 64'(exp_bytes));
    n_start = 0; n_strobe = 0; exp_frames = 0; exp_bytes = 0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_req_ready"}, {32'h0, 28'h0, req_ready}, 64'h0);
    chk({tag, "_resp_valid"}, resp_valid, 64'h0);
    chk({tag, "_resp_id"}, resp_id, 64'h0);
    chk({tag, "_resp_crc"}, resp_crc, 64'h0);
    chk({tag, "_resp_err"}, resp_err, 64'h0);
    chk({tag, "_busy"}, busy, 64'h0);
    chk({tag, "_crc_start"}, crc_start, 64'h0);
    chk({tag, "_crc_dv"}, crc_data_valid, 64'h0);
    chk({tag, "_crc_data"}, crc_data, 64'h0);
  endtask

  initial begin
    int t;
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; resp_ready = 1'b0;
    crc_ready = 1'b0; crc_out = '0;
    n_start = 0; n_strobe = 0; exp_frames = 0; exp_bytes = 0;
    for (int k = 0; k < N; k++) begin pos[k] = 0; gap_left[k] = 0; end
    @(posedge clk); #1;
    chk_zero_outputs("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Standard check value on requester 0.
    add_frame(0, 1, 9);
    run_round("single", 200);
    chk("single_crc_const", last_resp_crc, 64'hCBF43926);

    // Wrap the pointer back to 0, then contention between 1 and 3 with a late frame on 1.
    add_frame(3, 0, 3);
    run_round("wrap", 200);
    id_log.delete();
    add_frame(1, 1, 9); add_frame(3, 0, 5);
    late_trig_k = 3; late_k = 1;
    run_round("contend", 400);
    late_trig_k = -1;
    chk("contend_n", 64'(id_log.size()), 64'd3);
    if (id_log.size() == 3) begin
      chk("contend_first", 64'(id_log[0]), 64'd1);
      chk("contend_second", 64'(id_log[1]), 64'd3);
      chk("contend_third", 64'(id_log[2]), 64'd1);
    end

    // Mid-frame gap on requester 2 plus a 5-cycle response stall.
    add_frame(2, 1, 9);
    force_gap_k = 2; stall_left = 5;
    run_round("gap_stall", 300);
    chk("gap_stall_crc_const", last_resp_crc, 64'hCBF43926);

    add_frame(0, 2, 1);
    run_round("one_byte", 100);
    chk("one_byte_crc_const", last_resp_crc, 64'hD202EF8D);

    // Reset while byte 4 is on the bus.
    add_frame(0, 1, 9);
    t = 0;
    while (pos[0] != 3 && t < 100) begin step(); t++; end
    if (t >= 100) chk("midreset_reach_byte4", 64'h0, 64'h1);
    rst = 1'b1; #1;
    chk_zero_outputs("midreset");
    for (int k = 0; k < N; k++) begin q_frm[k].delete(); exp_crc_q[k].delete(); pos[k] = 0; gap_left[k] = 0; end
    mptr = 0; hold_v = 0; prev_rv = 0;
    n_start = 0; n_strobe = 0; exp_frames = 0; exp_bytes = 0;
    @(posedge clk); #1 rst = 1'b0;
    add_frame(0, 1, 9);
    run_round("post_reset", 200);
    chk("post_reset_crc_const", last_resp_crc, 64'hCBF43926);

    // Randomized rounds: random subsets, lengths, gaps and response backpressure.
    rnd_gap = 1; rnd_rdy = 1;
    for (int r = 0; r < 25; r++) begin
      int mask;
      mask = $urandom_range(1, (1 << N) - 1);
      for (int k = 0; k < N; k++) if (mask[k]) add_frame(k, 0, $urandom_range(1, 12));
      run_round("random", 2000);
    end
    rnd_gap = 0; rnd_rdy = 0;

`ifdef CRC_ARB_TIMEOUT_EN
    eng_hold = 1; expect_to = 1;
    add_frame(2, 0, 4);
    run_round("timeout", 200);
    eng_hold = 0; expect_to = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
